// File: rtl/pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_pkg: stage indices, forwarding encoding, scoreboard field layout  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package pipe_pkg;

  localparam int STG_E  = 0;
  localparam int STG_M  = 1;
  localparam int FWD_RF = 0;

  // Low bits of every scoreboard entry; the destination address follows.
  localparam int ENT_VALID  = 0;
  localparam int ENT_WE     = 1;
  localparam int ENT_LOAD   = 2;
  localparam int ENT_CTRL_W = 3;

  function automatic int stg_w(input int depth);
    return depth - 1;
  endfunction

  function automatic int ent_w(input int aw);
    return ENT_CTRL_W + aw;
  endfunction

  // Entry 0 also carries the source addresses and their used flags.
  function automatic int head_w(input int aw, input int nsrc);
    return ENT_CTRL_W + aw + nsrc * (aw + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_track_entry.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_track_entry: one scoreboard register with sync reset and clear   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module pipe_track_entry
  import pipe_pkg::*;
#(
  parameter int W = ENT_CTRL_W + 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clr,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (reset || i_clr) r_q <= '0;
    else                r_q <= i_d;
  end

  assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_track.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_hazard_track: scoreboard-driven forwarding, load-use stall,      |
// | branch flush and saturating perf counters. Revision: 1.0              |
// +----------------------------------------------------------------------+
module pipe_hazard_track
  import pipe_pkg::*;
#(
  parameter  int AW        = 4,
  parameter  int NUM_SRC   = 2,
  parameter  int DEPTH     = 3,
  parameter  int LOAD_RDY  = 2,
  parameter  int NOFWD_REG = 15,
  parameter  int CNT_W     = 16,
  localparam int SW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_dec_valid,
  input  logic                  i_dec_we,
  input  logic                  i_dec_load,
  input  logic [AW-1:0]         i_dec_wa,
  input  logic [NUM_SRC*AW-1:0] i_dec_ra,
  input  logic [NUM_SRC-1:0]    i_dec_ra_used,
  input  logic                  i_branch_taken_e,
  output logic [NUM_SRC*SW-1:0] o_fwd_sel_e,
  output logic                  o_stall_f,
  output logic                  o_stall_d,
  output logic                  o_flush_d,
  output logic                  o_flush_e,
  output logic [DEPTH-1:0]      o_pipe_valid,
  output logic [CNT_W-1:0]      o_stall_cnt,
  output logic [CNT_W-1:0]      o_flush_cnt
);

  localparam int EW    = ent_w(AW);
  localparam int HW    = head_w(AW, NUM_SRC);
  localparam int STG_W = stg_w(DEPTH);
  localparam logic [AW-1:0]    c_NOFWD   = AW'(NOFWD_REG);
  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

  logic [DEPTH-1:0]      w_valid;
  logic [DEPTH-1:0]      w_we;
  logic [DEPTH-1:0]      w_load;
  logic [AW-1:0]         w_wa [DEPTH];
  logic [HW-1:0]         w_head_d;
  logic [HW-1:0]         w_head_q;
  logic [NUM_SRC*AW-1:0] w_e_ra;
  logic [NUM_SRC-1:0]    w_e_used;
  logic                  w_luh;
  logic                  w_flush_e;
  logic                  w_stall;
  logic [NUM_SRC*SW-1:0] w_fwd;
  logic [CNT_W-1:0]      r_stall_cnt;
  logic [CNT_W-1:0]      r_flush_cnt;

  assign w_head_d = {i_dec_ra_used, i_dec_ra, i_dec_wa, i_dec_load, i_dec_we, i_dec_valid};
  assign w_e_ra   = w_head_q[ENT_CTRL_W+AW +: NUM_SRC*AW];
  assign w_e_used = w_head_q[ENT_CTRL_W+AW+NUM_SRC*AW +: NUM_SRC];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      if (gi == STG_E) begin : g_head
        // A flushed or absent D instruction enters E as a bubble.
        pipe_track_entry #(.W(HW)) u_entry (
          .clk   (clk),
          .reset (reset),
          .i_clr (~i_dec_valid | w_flush_e),
          .i_d   (w_head_d),
          .o_q   (w_head_q)
        );
        assign w_valid[gi] = w_head_q[ENT_VALID];
        assign w_we[gi]    = w_head_q[ENT_WE];
        assign w_load[gi]  = w_head_q[ENT_LOAD];
        assign w_wa[gi]    = w_head_q[ENT_CTRL_W +: AW];
      end else begin : g_tail
        logic [EW-1:0] w_d;
        logic [EW-1:0] w_q;
        assign w_d = {w_wa[gi-1], w_load[gi-1], w_we[gi-1], w_valid[gi-1]};
        pipe_track_entry #(.W(EW)) u_entry (
          .clk   (clk),
          .reset (reset),
          .i_clr (1'b0),
          .i_d   (w_d),
          .o_q   (w_q)
        );
        assign w_valid[gi] = w_q[ENT_VALID];
        assign w_we[gi]    = w_q[ENT_WE];
        assign w_load[gi]  = w_q[ENT_LOAD];
        assign w_wa[gi]    = w_q[ENT_CTRL_W +: AW];
      end
    end
  endgenerate

  // A load whose data would still be unavailable once the consumer reaches E.
  always_comb begin
    w_luh = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if ((i + 1) < LOAD_RDY && i_dec_ra_used[k] &&
            i_dec_ra[k*AW +: AW] != c_NOFWD &&
            w_valid[i] && w_we[i] && w_load[i] &&
            w_wa[i] == i_dec_ra[k*AW +: AW])
          w_luh = 1'b1;
      end
    end
    w_luh = w_luh & i_dec_valid;
  end

  // Descending scan so the youngest matching producer overwrites older ones.
  always_comb begin
    w_fwd = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_fwd[k*SW +: SW] = SW'(FWD_RF);
      if (w_valid[STG_E] && w_e_used[k] && w_e_ra[k*AW +: AW] != c_NOFWD) begin
        for (int j = STG_W; j >= 1; j--) begin
          if (w_valid[j] && w_we[j] && w_wa[j] == w_e_ra[k*AW +: AW])
            w_fwd[k*SW +: SW] = SW'(j);
        end
      end
    end
  end

  assign w_flush_e = i_branch_taken_e | w_luh;
  assign w_stall   = w_luh & ~i_branch_taken_e;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && r_stall_cnt != c_CNT_MAX)
        r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
      if (i_branch_taken_e && r_flush_cnt != c_CNT_MAX)
        r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
    end
  end

  assign o_fwd_sel_e  = w_fwd;
  assign o_stall_f    = w_stall;
  assign o_stall_d    = w_stall;
  assign o_flush_d    = i_branch_taken_e;
  assign o_flush_e    = w_flush_e;
  assign o_pipe_valid = w_valid;
  assign o_stall_cnt  = r_stall_cnt;
  assign o_flush_cnt  = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_track.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pipe_hazard_track: two configurations driven in lockstep, checked  |
// | by a queue scoreboard against an instruction-level reference model.   |
// +----------------------------------------------------------------------+
module tb_pipe_hazard_track;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       dv, dwe, dld, br;
  logic [3:0] dwa;
  logic [7:0] dra;
  logic [1:0] dused;

  logic [3:0]  fwd_a, fwd_b;
  logic        sf_a, sd_a, fd_a, fe_a, sf_b, sd_b, fd_b, fe_b;
  logic [2:0]  pv_a;
  logic [3:0]  pv_b;
  logic [15:0] sc_a, fc_a;
  logic [1:0]  sc_b, fc_b;

  pipe_hazard_track u_dut_a (
    .clk(clk), .reset(reset), .i_dec_valid(dv), .i_dec_we(dwe), .i_dec_load(dld),
    .i_dec_wa(dwa), .i_dec_ra(dra), .i_dec_ra_used(dused), .i_branch_taken_e(br),
    .o_fwd_sel_e(fwd_a), .o_stall_f(sf_a), .o_stall_d(sd_a), .o_flush_d(fd_a),
    .o_flush_e(fe_a), .o_pipe_valid(pv_a), .o_stall_cnt(sc_a), .o_flush_cnt(fc_a)
  );

  pipe_hazard_track #(.DEPTH(4), .LOAD_RDY(3), .CNT_W(2)) u_dut_b (
    .clk(clk), .reset(reset), .i_dec_valid(dv), .i_dec_we(dwe), .i_dec_load(dld),
    .i_dec_wa(dwa), .i_dec_ra(dra), .i_dec_ra_used(dused), .i_branch_taken_e(br),
    .o_fwd_sel_e(fwd_b), .o_stall_f(sf_b), .o_stall_d(sd_b), .o_flush_d(fd_b),
    .o_flush_e(fe_b), .o_pipe_valid(pv_b), .o_stall_cnt(sc_b), .o_flush_cnt(fc_b)
  );

  typedef struct {
    bit v; bit we; bit ld; int wa; int ra0; int ra1; bit u0; bit u1;
  } ins_t;

  typedef struct {
    int fwd0; int fwd1; bit sf; bit sd; bit fd; bit fe; int pv; int sc; int fc;
  } exp_t;

  // Model: for each configuration, the instruction occupying each of E..W.
  ins_t m [2][8];
  int   m_sc [2];
  int   m_fc [2];
  bit   known = 1'b0;
  exp_t qa[$];
  exp_t qb[$];
  int   n_chk = 0;
  int   n_pass = 0;

  function automatic int dep(input int mi);  return (mi == 0) ? 3 : 4; endfunction
  function automatic int lrdy(input int mi); return (mi == 0) ? 2 : 3; endfunction
  function automatic int cmax(input int mi); return (mi == 0) ? 65535 : 3; endfunction
  function automatic int ra_of(input ins_t x, input int k); return (k == 0) ? x.ra0 : x.ra1; endfunction
  function automatic bit used_of(input ins_t x, input int k); return (k == 0) ? x.u0 : x.u1; endfunction

  function automatic ins_t mk(input bit v, input bit we, input bit ld, input int wa,
                              input int ra0, input int ra1, input bit u0, input bit u1);
    ins_t x;
    x.v = v; x.we = we; x.ld = ld; x.wa = wa; x.ra0 = ra0; x.ra1 = ra1; x.u0 = u0; x.u1 = u1;
    return x;
  endfunction

  function automatic exp_t predict(input int mi, input ins_t d, input bit b);
    exp_t e;
    bit   luh = 1'b0;
    int   sel [2];
    for (int k = 0; k < 2; k++) begin
      // A load is usable by the consumer only if it reaches LOAD_RDY by the time the consumer is in E.
      if (d.v && used_of(d, k) && ra_of(d, k) != 15)
        for (int i = 0; i < dep(mi); i++)
          if (m[mi][i].v && m[mi][i].we && m[mi][i].ld && m[mi][i].wa == ra_of(d, k)
              && i + 1 < lrdy(mi))
            luh = 1'b1;
      // Youngest producer older than the E instruction supplies the operand.
      sel[k] = 0;
      if (m[mi][0].v && used_of(m[mi][0], k) && ra_of(m[mi][0], k) != 15) begin
        for (int j = 1; j < dep(mi); j++)
          if (sel[k] == 0 && m[mi][j].v && m[mi][j].we && m[mi][j].wa == ra_of(m[mi][0], k))
            sel[k] = j;
        if (sel[k] != 0 && m[mi][sel[k]].ld && sel[k] < lrdy(mi))
          $error("protocol violation: cfg %0d source %0d selects unready load", mi, k);
      end
    end
    e.fwd0 = sel[0];
    e.fwd1 = sel[1];
    e.fd   = b;
    e.fe   = b | luh;
    e.sf   = luh & ~b;
    e.sd   = luh & ~b;
    e.pv   = 0;
    for (int i = 0; i < dep(mi); i++) if (m[mi][i].v) e.pv += (1 << i);
    e.sc   = m_sc[mi];
    e.fc   = m_fc[mi];
    return e;
  endfunction

  task automatic advance(input int mi, input ins_t d, input bit b, input bit rst, input exp_t e);
    ins_t z = mk(0, 0, 0, 0, 0, 0, 0, 0);
    if (rst) begin
      for (int i = 0; i < 8; i++) m[mi][i] = z;
      m_sc[mi] = 0;
      m_fc[mi] = 0;
    end else begin
      for (int i = dep(mi) - 1; i >= 1; i--) m[mi][i] = m[mi][i-1];
      m[mi][0] = (d.v && !e.fe) ? d : z;
      if (e.sd && m_sc[mi] < cmax(mi)) m_sc[mi]++;
      if (b && m_fc[mi] < cmax(mi)) m_fc[mi]++;
    end
  endtask

  task automatic chk(input string name, input int act, input int expv);
    n_chk++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
  endtask

  task automatic cyc(input ins_t d, input bit b, input bit rst);
    exp_t ea, eb;
    @(posedge clk);
    #1;
    reset = rst; dv = d.v; dwe = d.we; dld = d.ld; dwa = 4'(d.wa);
    dra = {4'(d.ra1), 4'(d.ra0)}; dused = {d.u1, d.u0}; br = b;
    ea = predict(0, d, b);
    eb = predict(1, d, b);
    if (known) begin
      qa.push_back(ea);
      qb.push_back(eb);
    end
    advance(0, d, b, rst, ea);
    advance(1, d, b, rst, eb);
    if (rst) known = 1'b1;
  endtask

  // Monitor: outputs are present every cycle; compare mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (qa.size() > 0) begin
        e = qa.pop_front();
        chk("a_fwd0", int'(fwd_a[1:0]), e.fwd0);
        chk("a_fwd1", int'(fwd_a[3:2]), e.fwd1);
        chk("a_stall_f", int'(sf_a), int'(e.sf));
        chk("a_stall_d", int'(sd_a), int'(e.sd));
        chk("a_flush_d", int'(fd_a), int'(e.fd));
        chk("a_flush_e", int'(fe_a), int'(e.fe));
        chk("a_pipe_valid", int'(pv_a), e.pv);
        chk("a_stall_cnt", int'(sc_a), e.sc);
        chk("a_flush_cnt", int'(fc_a), e.fc);
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        chk("b_fwd0", int'(fwd_b[1:0]), e.fwd0);
        chk("b_fwd1", int'(fwd_b[3:2]), e.fwd1);
        chk("b_stall_f", int'(sf_b), int'(e.sf));
        chk("b_stall_d", int'(sd_b), int'(e.sd));
        chk("b_flush_d", int'(fd_b), int'(e.fd));
        chk("b_flush_e", int'(fe_b), int'(e.fe));
        chk("b_pipe_valid", int'(pv_b), e.pv);
        chk("b_stall_cnt", int'(sc_b), e.sc);
        chk("b_flush_cnt", int'(fc_b), e.fc);
      end
    end
  end

  function automatic int rreg();
    return ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 3));
  endfunction

  initial begin
    ins_t nop, ldr5, use5;
    nop  = mk(0, 0, 0, 0, 0, 0, 0, 0);
    ldr5 = mk(1, 1, 1, 5, 0, 0, 0, 0);
    use5 = mk(1, 1, 0, 9, 0, 5, 0, 1);
    reset = 1'b1; dv = 1'b0; dwe = 1'b0; dld = 1'b0; dwa = '0; dra = '0; dused = '0; br = 1'b0;

    // Reset held with a load presented in D.
    cyc(mk(1, 1, 1, 5, 5, 5, 1, 1), 1'b0, 1'b1);
    cyc(mk(1, 1, 1, 5, 5, 5, 1, 1), 1'b0, 1'b1);
    cyc(nop, 1'b0, 1'b0);

    // ALU chain, back-to-back and with one unrelated instruction between.
    cyc(mk(1, 1, 0, 3, 0, 0, 0, 0), 1'b0, 1'b0);
    cyc(mk(1, 1, 0, 8, 3, 0, 1, 0), 1'b0, 1'b0);
    cyc(mk(1, 1, 0, 3, 0, 0, 0, 0), 1'b0, 1'b0);
    cyc(mk(1, 1, 0, 7, 1, 1, 0, 0), 1'b0, 1'b0);
    cyc(mk(1, 1, 0, 8, 3, 0, 1, 0), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(nop, 1'b0, 1'b0);

    // Load-use: consumer re-presented while stalled.
    cyc(ldr5, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(use5, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(nop, 1'b0, 1'b0);

    // Branch taken in the same cycle as a load-use hazard.
    cyc(ldr5, 1'b0, 1'b0);
    cyc(use5, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc(nop, 1'b0, 1'b0);

    // Youngest producer, never-forwarded register, unused operand.
    cyc(mk(1, 1, 0, 2, 0, 0, 0, 0), 1'b0, 1'b0);
    cyc(mk(1, 1, 0, 2, 0, 0, 0, 0), 1'b0, 1'b0);
    cyc(mk(1, 1, 0, 9, 2, 2, 1, 1), 1'b0, 1'b0);
    cyc(mk(1, 1, 0, 15, 0, 0, 0, 0), 1'b0, 1'b0);
    cyc(mk(1, 1, 0, 9, 15, 15, 1, 1), 1'b0, 1'b0);
    cyc(mk(1, 1, 0, 6, 0, 0, 0, 0), 1'b0, 1'b0);
    cyc(mk(1, 1, 0, 9, 6, 6, 0, 0), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(nop, 1'b0, 1'b0);

    // Repeated load-use pairs push the narrow counter into saturation.
    for (int r = 0; r < 5; r++) begin
      cyc(ldr5, 1'b0, 1'b0);
      cyc(use5, 1'b0, 1'b0);
      cyc(use5, 1'b0, 1'b0);
      cyc(nop, 1'b0, 1'b0);
    end

    // Randomized traffic over a small register set to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      ins_t d;
      d = mk($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
             rreg(), rreg(), rreg(), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      cyc(d, $urandom_range(0, 9) == 0, $urandom_range(0, 499) == 0);
    end

    cyc(nop, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
